// File: rtl/minirisc_debug_port_if.sv
// Debug readout bus: board switches/LEDs plus the CPU register-file and data-memory debug ports.
// The readout engine uses the master modport; the board/CPU side uses slave.
interface minirisc_debug_port_if #(
  parameter int DATA_W = 32,
  parameter int DISP_W = 16,
  parameter int SEL_W  = 10,
  parameter int DM_AW  = 10
);
  logic [1:0]        mode;
  logic              half;
  logic [SEL_W-1:0]  sel_in;
  logic [4:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              dm_req;
  logic              dm_gnt;
  logic [DM_AW-1:0]  dm_addr;
  logic [DATA_W-1:0] dm_data;
  logic [DATA_W-1:0] pc_in;
  logic [DISP_W-1:0] disp_out;
  logic              disp_valid;
  logic              sel_err;

  modport master (
    input  mode, half, sel_in, rf_data, dm_gnt, dm_data, pc_in,
    output rf_addr, dm_req, dm_addr, disp_out, disp_valid, sel_err
  );

  modport slave (
    output mode, half, sel_in, rf_data, dm_gnt, dm_data, pc_in,
    input  rf_addr, dm_req, dm_addr, disp_out, disp_valid, sel_err
  );
endinterface

// File: rtl/minirisc_debug_port.sv
// Board-side readout engine: debounced switch selection fetches a register-file, data-memory
// or status word and latches half of it onto the LEDs, re-reading periodically while idle.
module minirisc_debug_port #(
  parameter int DATA_W         = 32,
  parameter int DISP_W         = 16,
  parameter int SEL_W          = 10,
  parameter int DM_AW          = 10,
  parameter int STABLE_CYCLES  = 4,
  parameter int REFRESH_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst,
  minirisc_debug_port_if.master dbg
);
  localparam int VEC_W = SEL_W + 3;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int REF_W = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_RF_RD, S_DM_REQ, S_DM_WAIT, S_CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  raw_vec, sync1_q, sync2_q, last_q, acc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REF_W-1:0]  ref_q;
  logic [DATA_W-1:0] count_q;
  logic [DISP_W-1:0] disp_q;
  logic [4:0]        rf_addr_q;
  logic [DM_AW-1:0]  dm_addr_q;
  logic              pend_q, pend_d, cur_half_q, disp_valid_q, sel_err_q;
  logic              accept, launch, sel_bad, rf_oor, dm_oor, st_oor;
  logic              capture, cap_half, cap_err, dm_req;
  logic [DATA_W-1:0] status_word, cap_word;
  logic [1:0]        acc_mode;
  logic              acc_half;
  logic [SEL_W-1:0]  acc_sel;

  assign raw_vec  = {dbg.mode, dbg.half, dbg.sel_in};
  assign acc_mode = acc_q[VEC_W-1 -: 2];
  assign acc_half = acc_q[SEL_W];
  assign acc_sel  = acc_q[SEL_W-1:0];

  // Hold time restarts on any change; only a vector differing from the accepted one launches a read.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != last_q)
      cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_W'(STABLE_CYCLES))
      cnt_d = cnt_q + 1'b1;
  end
  assign accept = (cnt_d == CNT_W'(STABLE_CYCLES)) && (sync2_q != acc_q);
  assign launch = (state_q == S_IDLE) && (pend_q || (ref_q == REF_W'(REFRESH_CYCLES - 1)));
  assign pend_d = accept | (pend_q & ~launch);

  assign rf_oor = 32'(acc_sel) >= 32'd32;
  assign st_oor = 32'(acc_sel) >= 32'd2;
  generate
    if (DM_AW < SEL_W) begin : g_dm_rng
      assign dm_oor = |acc_sel[SEL_W-1:DM_AW];
    end else begin : g_dm_full
      assign dm_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    case (acc_mode)
      2'd0:    sel_bad = rf_oor;
      2'd1:    sel_bad = dm_oor;
      2'd2:    sel_bad = st_oor;
      default: sel_bad = 1'b1;
    endcase
  end

  assign status_word = (acc_sel == SEL_W'(0)) ? dbg.pc_in :
                       (acc_sel == SEL_W'(1)) ? count_q : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          if (sel_bad)              state_d = S_CAPTURE;
          else if (acc_mode == 2'd0) state_d = S_RF_RD;
          else if (acc_mode == 2'd1) state_d = S_DM_REQ;
          else                      state_d = S_CAPTURE;
        end
      end
      S_RF_RD:   state_d = S_CAPTURE;
      S_DM_REQ:  if (dbg.dm_gnt) state_d = S_DM_WAIT;
      S_DM_WAIT: state_d = S_CAPTURE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The display latch loads on the edge that enters CAPTURE, from whichever source fed it.
  always_comb begin
    dm_req   = (state_q == S_DM_REQ);
    capture  = 1'b0;
    cap_word = '0;
    cap_half = cur_half_q;
    cap_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        capture  = launch && (state_d == S_CAPTURE);
        cap_half = acc_half;
        cap_err  = sel_bad;
        cap_word = sel_bad ? '0 : status_word;
      end
      S_RF_RD: begin
        capture  = 1'b1;
        cap_word = dbg.rf_data;
      end
      S_DM_WAIT: begin
        capture  = 1'b1;
        cap_word = dbg.dm_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      last_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      ref_q        <= '0;
      count_q      <= '0;
      cur_half_q   <= 1'b0;
      rf_addr_q    <= '0;
      dm_addr_q    <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      count_q <= count_q + 1'b1;
      if (accept) acc_q <= sync2_q;
      if (state_q == S_IDLE && !launch) ref_q <= ref_q + 1'b1;
      else                              ref_q <= '0;
      if (launch) cur_half_q <= acc_half;
      if (launch && state_d == S_RF_RD)  rf_addr_q <= acc_sel[4:0];
      if (launch && state_d == S_DM_REQ) dm_addr_q <= acc_sel[DM_AW-1:0];
      if (capture) begin
        disp_q    <= cap_half ? cap_word[DATA_W-1:DISP_W] : cap_word[DISP_W-1:0];
        sel_err_q <= cap_err;
      end
      // A read superseded by a newer selection still updates the LEDs but stays marked invalid.
      if (accept)                  disp_valid_q <= 1'b0;
      else if (capture && !pend_d) disp_valid_q <= 1'b1;
    end
  end

  assign dbg.rf_addr    = rf_addr_q;
  assign dbg.dm_req     = dm_req;
  assign dbg.dm_addr    = dm_addr_q;
  assign dbg.disp_out   = disp_q;
  assign dbg.disp_valid = disp_valid_q;
  assign dbg.sel_err    = sel_err_q;
endmodule

// File: tb/tb_minirisc_debug_port.sv
// Directed bench for the debug readout engine with a selection-level reference model.
module tb_minirisc_debug_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  minirisc_debug_port_if #(.DATA_W(32), .DISP_W(16), .SEL_W(10), .DM_AW(10)) dbg();

  minirisc_debug_port #(
    .DATA_W(32), .DISP_W(16), .SEL_W(10), .DM_AW(10),
    .STABLE_CYCLES(4), .REFRESH_CYCLES(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg)
  );

  logic [31:0] rf  [32];
  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en = 1'b0;
  int          tb_mode = 0, tb_half = 0, tb_sel = 0;
  logic [31:0] tb_cyc;

  // CPU-side models: combinational register file, data memory answering one cycle after grant
  assign dbg.rf_data = rf[dbg.rf_addr];
  always @(posedge clk) if (dbg.dm_req && dbg.dm_gnt) dbg.dm_data <= mem[dbg.dm_addr];
  always @(posedge clk) tb_cyc <= rst ? 32'd0 : tb_cyc + 32'd1;

  function automatic logic [31:0] model_word(input int m, input int s);
    if (m == 0 && s < 32)   return rf[s];
    if (m == 1 && s < 1024) return mem[s];
    if (m == 2 && s == 0)   return dbg.pc_in;
    return 32'd0;
  endfunction

  function automatic logic [15:0] model_disp(input int m, input int h, input int s);
    logic [31:0] w;
    w = model_word(m, s);
    return (h != 0) ? w[31:16] : w[15:0];
  endfunction

  function automatic logic model_err(input int m, input int s);
    return !((m == 0 && s < 32) || (m == 1 && s < 1024) || (m == 2 && s < 2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input int m, input int h, input int s);
    chk_en      = 1'b0;
    dbg.mode    = 2'(m);
    dbg.half    = h[0];
    dbg.sel_in  = 10'(s);
    tb_mode = m; tb_half = h; tb_sel = s;
  endtask

  task automatic settle();
    chk_en = 1'b1;
    tick(4);
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_valid", 32'(dbg.disp_valid), 32'd1);
      chk("model_disp", 32'(dbg.disp_out), 32'(model_disp(tb_mode, tb_half, tb_sel)));
      chk("model_err", 32'(dbg.sel_err), 32'(model_err(tb_mode, tb_sel)));
    end
  end

  initial begin
    int hits, bad, n, drops;
    logic [31:0] e;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rf[5] = 32'h1234_ABCD; rf[2] = 32'd10; mem[3] = 32'h0000_FFF6;
    dbg.mode = 2'd0; dbg.half = 1'b0; dbg.sel_in = '0;
    dbg.dm_gnt = 1'b1; dbg.pc_in = 32'h0000_0020;

    chk("pin_model_rf5_hi", 32'(model_disp(0, 1, 5)), 32'h1234);
    chk("pin_model_err", 32'(model_err(2, 7)), 32'd1);

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("rst_disp", 32'(dbg.disp_out), 32'd0);
    chk("rst_valid", 32'(dbg.disp_valid), 32'd0);
    chk("rst_err", 32'(dbg.sel_err), 32'd0);
    chk("rst_dm_req", 32'(dbg.dm_req), 32'd0);
    chk("rst_rf_addr", 32'(dbg.rf_addr), 32'd0);
    chk("rst_dm_addr", 32'(dbg.dm_addr), 32'd0);

    set_sw(0, 0, 5);
    tick(7);
    chk("rf_addr_a1", 32'(dbg.rf_addr), 32'd5);
    chk("rf_disp_a1", 32'(dbg.disp_out), 32'd0);
    tick(1);
    chk("rf_disp_a2", 32'(dbg.disp_out), 32'h0000_ABCD);
    chk("rf_valid_a2", 32'(dbg.disp_valid), 32'd1);
    $display("read rf[5] low  -> disp=0x%04h", dbg.disp_out);
    settle();

    set_sw(0, 1, 5);
    tick(6);
    chk("half_valid_drop", 32'(dbg.disp_valid), 32'd0);
    chk("half_disp_hold", 32'(dbg.disp_out), 32'h0000_ABCD);
    tick(2);
    chk("half_disp", 32'(dbg.disp_out), 32'h0000_1234);
    $display("read rf[5] high -> disp=0x%04h", dbg.disp_out);
    settle();

    dbg.dm_gnt = 1'b0;
    set_sw(1, 0, 3);
    tick(6);
    chk("dm_req_a", 32'(dbg.dm_req), 32'd0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (dbg.dm_req) hits++;
      chk("dm_addr_hold", 32'(dbg.dm_addr), 32'd3);
      if (i == 5) dbg.dm_gnt = 1'b1;
    end
    tick(1);
    chk("dm_req_after_gnt", 32'(dbg.dm_req), 32'd0);
    chk("dm_valid_wait", 32'(dbg.disp_valid), 32'd0);
    tick(1);
    chk("dm_disp", 32'(dbg.disp_out), 32'h0000_FFF6);
    chk("dm_req_cycles", 32'(hits), 32'd6);
    $display("read mem[3] after 5 stalls -> disp=0x%04h req_cycles=%0d", dbg.disp_out, hits);
    settle();

    set_sw(1, 0, 7);
    tick(2);
    set_sw(1, 0, 3);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (!dbg.disp_valid || dbg.dm_req || dbg.disp_out != 16'hFFF6) bad++;
    end
    chk("glitch_no_read", 32'(bad), 32'd0);
    $display("glitch sel 3->7->3 -> disp=0x%04h", dbg.disp_out);
    settle();

    set_sw(0, 0, 40);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (dbg.dm_req) hits++;
    end
    chk("err_valid_drop", 32'(dbg.disp_valid), 32'd0);
    tick(1);
    chk("err_disp", 32'(dbg.disp_out), 32'd0);
    chk("err_flag", 32'(dbg.sel_err), 32'd1);
    chk("err_rf_addr", 32'(dbg.rf_addr), 32'd5);
    chk("err_no_dm_req", 32'(hits), 32'd0);
    $display("read rf[40] -> disp=0x%04h sel_err=%0d", dbg.disp_out, dbg.sel_err);
    settle();

    set_sw(2, 0, 0);
    tick(7);
    chk("pc_disp", 32'(dbg.disp_out), 32'h0000_0020);
    chk("pc_err", 32'(dbg.sel_err), 32'd0);
    $display("read status pc -> disp=0x%04h", dbg.disp_out);
    settle();

    set_sw(2, 0, 1);
    tick(7);
    e = tb_cyc - 32'd1;
    chk("cyc_disp", 32'(dbg.disp_out), 32'(e[15:0]));
    $display("read status cycle counter -> disp=0x%04h", dbg.disp_out);

    set_sw(0, 0, 2);
    tick(8);
    chk("rf2_disp", 32'(dbg.disp_out), 32'd10);
    rf[2] = 32'd9;
    n = 0; drops = 0;
    while (n < 1100 && dbg.disp_out != 16'd9) begin
      tick(1);
      n++;
      if (!dbg.disp_valid) drops++;
    end
    chk("refresh_in_time", 32'(n <= 1026), 32'd1);
    chk("refresh_valid_kept", 32'(drops), 32'd0);
    $display("refresh rf[2] 10->9 seen after %0d cycles", n);
    settle();

    dbg.dm_gnt = 1'b0;
    set_sw(1, 0, 3);
    tick(8);
    set_sw(0, 0, 5);
    tick(6);
    chk("pend_valid_low", 32'(dbg.disp_valid), 32'd0);
    chk("pend_dm_req", 32'(dbg.dm_req), 32'd1);
    dbg.dm_gnt = 1'b1;
    tick(2);
    chk("pend_inflight_disp", 32'(dbg.disp_out), 32'h0000_FFF6);
    chk("pend_inflight_valid", 32'(dbg.disp_valid), 32'd0);
    tick(3);
    chk("pend_new_disp", 32'(dbg.disp_out), 32'h0000_ABCD);
    chk("pend_new_valid", 32'(dbg.disp_valid), 32'd1);
    $display("mid-read reselect -> disp=0x%04h", dbg.disp_out);
    settle();

    dbg.dm_gnt = 1'b0;
    set_sw(1, 0, 4);
    tick(7);
    chk("rstdm_req_before", 32'(dbg.dm_req), 32'd1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rstdm_req", 32'(dbg.dm_req), 32'd0);
    chk("rstdm_disp", 32'(dbg.disp_out), 32'd0);
    chk("rstdm_valid", 32'(dbg.disp_valid), 32'd0);
    chk("rstdm_err", 32'(dbg.sel_err), 32'd0);
    rst = 1'b0;
    dbg.dm_gnt = 1'b1;
    set_sw(2, 0, 1);
    tick(7);
    chk("rstdm_counter", 32'(dbg.disp_out), 32'h0000_0006);
    chk("rstdm_counter_valid", 32'(dbg.disp_valid), 32'd1);
    $display("reset in DM_REQ, then cycle counter -> disp=0x%04h", dbg.disp_out);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
